// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises instruction fetch and load/store requests onto the
// shared RAM port (MOV/MOC handshake), round-robin with a data burst lock and MOC timeout.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        F_REQ,
  input  logic [31:0] F_ADDR,
  input  logic        D_REQ,
  input  logic        D_RW,
  input  logic [2:0]  D_MS,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic        D_LOCK,
  output logic        F_DONE,
  output logic        D_DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        BUSY,
  output logic        MOV,
  output logic        RW,
  output logic [2:0]  MS,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  input  logic [31:0] M_RDATA,
  input  logic        MOC
);

  localparam logic [2:0] MS_WORD     = 3'b010;
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        owner_d, owner_d_nxt;
  logic        last_d, last_d_nxt;
  logic        locked, locked_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        grant_d, timed_out;
  logic        mov_nxt, rw_nxt, busy_nxt;
  logic        f_done_nxt, d_done_nxt, err_nxt;
  logic [2:0]  ms_nxt;
  logic [31:0] addr_nxt, wdata_nxt, rdata_nxt;

  // A locked burst keeps the port for data; otherwise a tie goes to whoever did not own it last.
  assign grant_d   = D_REQ && (locked || !F_REQ || !last_d);
  assign timed_out = !MOC && (({1'b0, cnt} + 9'd1) == TIMEOUT_LIM);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      owner_d <= 1'b0;
      last_d  <= 1'b1;
      locked  <= 1'b0;
      cnt     <= 8'd0;
      MOV     <= 1'b0;
      RW      <= 1'b0;
      MS      <= 3'b000;
      M_ADDR  <= 32'd0;
      M_WDATA <= 32'd0;
      RDATA   <= 32'd0;
      F_DONE  <= 1'b0;
      D_DONE  <= 1'b0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner_d <= owner_d_nxt;
      last_d  <= last_d_nxt;
      locked  <= locked_nxt;
      cnt     <= cnt_nxt;
      MOV     <= mov_nxt;
      RW      <= rw_nxt;
      MS      <= ms_nxt;
      M_ADDR  <= addr_nxt;
      M_WDATA <= wdata_nxt;
      RDATA   <= rdata_nxt;
      F_DONE  <= f_done_nxt;
      D_DONE  <= d_done_nxt;
      ERR     <= err_nxt;
      BUSY    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (F_REQ || D_REQ) state_nxt = S_WAIT;
      S_WAIT:    if (MOC || timed_out) state_nxt = S_RELEASE;
      S_RELEASE: if (!MOC) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d_nxt = owner_d;
    last_d_nxt  = last_d;
    locked_nxt  = locked;
    cnt_nxt     = cnt;
    mov_nxt     = MOV;
    rw_nxt      = RW;
    ms_nxt      = MS;
    addr_nxt    = M_ADDR;
    wdata_nxt   = M_WDATA;
    rdata_nxt   = RDATA;
    f_done_nxt  = 1'b0;
    d_done_nxt  = 1'b0;
    err_nxt     = 1'b0;
    busy_nxt    = (state_nxt != S_IDLE);
    case (state)
      S_IDLE: begin
        if (F_REQ || D_REQ) begin
          owner_d_nxt = grant_d;
          mov_nxt     = 1'b1;
          cnt_nxt     = 8'd0;
          if (grant_d) begin
            rw_nxt     = D_RW;
            ms_nxt     = D_MS;
            addr_nxt   = D_ADDR;
            wdata_nxt  = D_WDATA;
            locked_nxt = D_LOCK;
          end else begin
            rw_nxt     = 1'b0;
            ms_nxt     = MS_WORD;
            addr_nxt   = F_ADDR;
            locked_nxt = 1'b0;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt + 8'd1;
        // MOC takes priority over a timeout landing on the same edge.
        if (MOC) begin
          if (!RW) rdata_nxt = M_RDATA;
          mov_nxt    = 1'b0;
          f_done_nxt = !owner_d;
          d_done_nxt = owner_d;
          last_d_nxt = owner_d;
        end else if (timed_out) begin
          mov_nxt    = 1'b0;
          f_done_nxt = !owner_d;
          d_done_nxt = owner_d;
          err_nxt    = 1'b1;
          last_d_nxt = owner_d;
          locked_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and random request streams checked against a
// transaction-level model of the arbitration, handshake timing and timeout rules.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_rw, d_lock, moc;
  logic [31:0] f_addr, d_addr, d_wdata, m_rdata;
  logic [2:0]  d_ms;
  logic        f_done, d_done, err, busy, mov, rw;
  logic [2:0]  ms;
  logic [31:0] rdata, m_addr, m_wdata;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(clk), .RESET(rst),
    .F_REQ(f_req), .F_ADDR(f_addr),
    .D_REQ(d_req), .D_RW(d_rw), .D_MS(d_ms), .D_ADDR(d_addr), .D_WDATA(d_wdata), .D_LOCK(d_lock),
    .F_DONE(f_done), .D_DONE(d_done), .ERR(err), .RDATA(rdata), .BUSY(busy),
    .MOV(mov), .RW(rw), .MS(ms), .M_ADDR(m_addr), .M_WDATA(m_wdata),
    .M_RDATA(m_rdata), .MOC(moc)
  );

  always #5 clk = ~clk;

  // lat: edges after issue at which the RAM raises MOC (0 = never); hold: extra MOC-high samples.
  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [2:0]  ms;
    logic [31:0] wdata;
    logic        lock;
    int          lat;
    int          hold;
    logic [31:0] rd;
  } acc_t;

  acc_t fq[$];
  acc_t dq[$];
  acc_t cur;

  int nchecks = 0;
  int nerrors = 0;

  int          ph;
  int          edge_n, issue_e, done_e, rel_e;
  logic        own_d, last_d, locked, cur_to, pres_f, pres_d;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic        exp_rw;
  logic [2:0]  exp_ms;

  function automatic acc_t mk(input logic [31:0] addr, input logic rw_i, input logic [2:0] ms_i,
                              input logic [31:0] wdata, input logic lock, input int lat,
                              input int hold, input logic [31:0] rd);
    acc_t a;
    a.addr = addr; a.rw = rw_i; a.ms = ms_i; a.wdata = wdata;
    a.lock = lock; a.lat = lat; a.hold = hold; a.rd = rd;
    return a;
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nerrors++;
      $error("FAIL %s/%s: observed %h expected %h", tag, what, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input logic ef, input logic ed, input logic ee);
    chk(tag, "mov",     32'(mov),    32'(ph == 1));
    chk(tag, "busy",    32'(busy),   32'(ph != 0));
    chk(tag, "f_done",  32'(f_done), 32'(ef));
    chk(tag, "d_done",  32'(d_done), 32'(ed));
    chk(tag, "err",     32'(err),    32'(ee));
    chk(tag, "rdata",   rdata,       exp_rdata);
    chk(tag, "m_addr",  m_addr,      exp_addr);
    chk(tag, "rw",      32'(rw),     32'(exp_rw));
    chk(tag, "ms",      32'(ms),     32'(exp_ms));
    chk(tag, "m_wdata", m_wdata,     exp_wdata);
  endtask

  task automatic model_reset();
    ph = 0; last_d = 1'b1; locked = 1'b0; own_d = 1'b0; cur_to = 1'b0;
    exp_rdata = 32'd0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_rw = 1'b0; exp_ms = 3'd0;
    fq.delete(); dq.delete();
  endtask

  // Requesters present real requests only when the port will sample them; otherwise noise.
  task automatic drive();
    if (ph == 0) begin
      f_req  = (fq.size() > 0);
      f_addr = f_req ? fq[0].addr : $urandom;
      d_req  = (dq.size() > 0);
      if (d_req) begin
        d_rw = dq[0].rw; d_ms = dq[0].ms; d_addr = dq[0].addr; d_wdata = dq[0].wdata; d_lock = dq[0].lock;
      end else begin
        d_rw = 1'($urandom); d_ms = 3'($urandom); d_addr = $urandom; d_wdata = $urandom; d_lock = 1'($urandom);
      end
    end else begin
      f_req = 1'($urandom); f_addr = $urandom;
      d_req = 1'($urandom); d_rw = 1'($urandom); d_ms = 3'($urandom);
      d_addr = $urandom; d_wdata = $urandom; d_lock = 1'($urandom);
    end
    pres_f = (ph == 0) && f_req;
    pres_d = (ph == 0) && d_req;
    moc = 1'b0;
    m_rdata = $urandom;
    if (ph == 1 && !cur_to && edge_n + 1 == issue_e + cur.lat) begin
      moc = 1'b1;
      m_rdata = cur.rd;
    end
    if (ph == 2 && edge_n + 1 < rel_e) moc = 1'b1;
  endtask

  task automatic step();
    logic ef, ed, ee;
    drive();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    ef = 1'b0; ed = 1'b0; ee = 1'b0;
    case (ph)
      0: if (pres_f || pres_d) begin
        own_d = pres_d && (locked || !pres_f || !last_d);
        cur = own_d ? dq[0] : fq[0];
        if (!own_d) begin
          cur.rw = 1'b0;
          cur.ms = 3'b010;
        end
        exp_addr = cur.addr; exp_rw = cur.rw; exp_ms = cur.ms;
        if (own_d) exp_wdata = cur.wdata;
        locked = own_d ? cur.lock : 1'b0;
        cur_to = (cur.lat == 0) || (cur.lat > TO);
        issue_e = edge_n;
        done_e = issue_e + (cur_to ? TO : cur.lat);
        ph = 1;
      end
      1: if (edge_n == done_e) begin
        ef = !own_d; ed = own_d; ee = cur_to;
        if (!cur_to && !cur.rw) exp_rdata = cur.rd;
        last_d = own_d;
        if (cur_to) locked = 1'b0;
        rel_e = edge_n + 1 + (cur_to ? 0 : cur.hold);
        if (own_d) void'(dq.pop_front());
        else void'(fq.pop_front());
        ph = 2;
      end
      2: if (edge_n == rel_e) ph = 0;
      default: ph = 0;
    endcase
    check_all($sformatf("e%0d", edge_n), ef, ed, ee);
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((ph != 0 || fq.size() > 0 || dq.size() > 0) && n < budget) begin
      step();
      n++;
    end
    nchecks++;
    assert (n < budget) else begin
      nerrors++;
      $error("FAIL run_budget: observed %0d cycles expected fewer than %0d", n, budget);
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_all("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    acc_t a;
    rst = 1'b1;
    f_req = 1'b0; f_addr = 32'd0; d_req = 1'b0; d_rw = 1'b0; d_ms = 3'd0;
    d_addr = 32'd0; d_wdata = 32'd0; d_lock = 1'b0; moc = 1'b0; m_rdata = 32'd0;
    edge_n = 0; issue_e = 0; done_e = 0; rel_e = 0; pres_f = 1'b0; pres_d = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Fetch only: MOC sampled three edges after issue.
    fq.push_back(mk(32'h10, 1'b0, 3'b010, 32'd0, 1'b0, 3, 0, 32'hE3A0_1005));
    run(50);
    chk("fetch_only", "rdata", rdata, 32'hE3A0_1005);

    // Tie after reset: fetch, data, fetch, data.
    do_reset();
    fq.push_back(mk(32'h100, 1'b0, 3'b010, 32'd0, 1'b0, 1, 0, 32'h1111_0000));
    fq.push_back(mk(32'h104, 1'b0, 3'b010, 32'd0, 1'b0, 2, 1, 32'h1111_0004));
    dq.push_back(mk(32'h200, 1'b0, 3'b010, 32'd0, 1'b0, 1, 0, 32'h2222_0000));
    dq.push_back(mk(32'h204, 1'b0, 3'b001, 32'd0, 1'b0, 3, 0, 32'h2222_0004));
    run(100);

    // LSM burst: locked words hold the port against a waiting fetch.
    fq.push_back(mk(32'h300, 1'b0, 3'b010, 32'd0, 1'b0, 1, 0, 32'h3333_0000));
    fq.push_back(mk(32'h304, 1'b0, 3'b010, 32'd0, 1'b0, 1, 0, 32'h3333_0004));
    for (int i = 0; i < 4; i++)
      dq.push_back(mk(32'h20 + 32'(4 * i), 1'b0, 3'b010, 32'd0, (i < 3), 1 + i, 0, 32'hD000_0000 + 32'(i)));
    run(150);

    // Write: RDATA must be left alone.
    dq.push_back(mk(32'h40, 1'b1, 3'b000, 32'h0000_00AB, 1'b0, 2, 0, 32'hDEAD_BEEF));
    run(50);
    chk("write", "m_wdata", m_wdata, 32'h0000_00AB);

    // Timeout of a locked access clears the lock; MOC on the timeout edge completes normally.
    dq.push_back(mk(32'h50, 1'b0, 3'b010, 32'd0, 1'b1, 0, 0, 32'hBAD0_0000));
    run(50);
    fq.push_back(mk(32'h60, 1'b0, 3'b010, 32'd0, 1'b0, TO, 0, 32'h6060_6060));
    dq.push_back(mk(32'h70, 1'b0, 3'b110, 32'd0, 1'b0, TO, 2, 32'h7070_7070));
    run(80);

    // Random streams, including timeouts, held MOC and burst locks.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) begin
        a = mk($urandom, 1'($urandom), 3'($urandom), $urandom, 1'($urandom),
               int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 2)), $urandom);
        if ($urandom_range(0, 1) == 1) dq.push_back(a);
        else fq.push_back(a);
      end
      run(400);
    end

    // Asynchronous reset in WAIT, then the first tie goes to fetch.
    dq.push_back(mk(32'h80, 1'b0, 3'b010, 32'd0, 1'b1, 0, 0, 32'd0));
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_all("reset_held", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    fq.push_back(mk(32'h90, 1'b0, 3'b010, 32'd0, 1'b0, 1, 0, 32'h9090_0000));
    dq.push_back(mk(32'hA0, 1'b0, 3'b010, 32'd0, 1'b0, 1, 0, 32'hA0A0_0000));
    step();
    chk("post_reset_tie", "m_addr", m_addr, 32'h90);
    run(50);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
